// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer and its consumers
// (PLL, domain reset synchronizers, status readout).
interface pll_reset_sequencer_if #(
  parameter int N_DOM = 3,
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             restart_req;
  logic             pll_rst;
  logic [N_DOM-1:0] dom_rst;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  modport master (
    input  pll_locked, restart_req,
    output pll_rst, dom_rst, ready, state, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_locked, restart_req,
    input  pll_rst, dom_rst, ready, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on the reference clock: pulses pll_rst, waits for a
// stable synchronized lock, then releases domain resets one by one.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int N_DOM         = 3,
  parameter int STAGGER       = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > STAGGER * N_DOM) ? STABLE_CYCLES : STAGGER * N_DOM;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0]    RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    REL_END     = TW'(N_DOM * STAGGER);
  localparam logic [N_DOM-1:0] ENTRY_MASK  = ~N_DOM'(1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic             pll_rst_q;
  logic [N_DOM-1:0] dom_rst_q;
  logic             ready_q;
  logic [CNT_W-1:0] retry_q;
  logic [CNT_W-1:0] loss_q;
  logic             lock_p0;
  logic             lock_p1;

  logic             lock_s;
  logic             lock_loss;
  logic             go_rst;
  logic [TW-1:0]    next_t;
  logic [N_DOM-1:0] rel_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lock_s = lock_p1;

  always_comb begin
    next_t    = timer_q + 1'b1;
    lock_loss = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;
    go_rst    = lock_loss || (bus.restart_req && (state_q != PLL_RST));
    // Bit k stays asserted until the RELEASE timer reaches k*STAGGER.
    rel_mask  = '1;
    for (int k = 0; k < N_DOM; k++) begin
      rel_mask[k] = (next_t < TW'(k * STAGGER));
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      timer_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= '1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
      lock_p0   <= 1'b0;
      lock_p1   <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchronizer for the asynchronous lock flag.
      lock_p0 <= bus.pll_locked;
      lock_p1 <= lock_p0;

      if (go_rst) begin
        state_q   <= PLL_RST;
        timer_q   <= '0;
        pll_rst_q <= 1'b1;
        dom_rst_q <= '1;
        ready_q   <= 1'b0;
        if (lock_loss) loss_q <= sat_inc(loss_q);
      end else begin
        case (state_q)
          PLL_RST: begin
            if (timer_q == RST_LAST) begin
              state_q   <= WAIT_LOCK;
              timer_q   <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              timer_q <= next_t;
            end
          end
          WAIT_LOCK: begin
            // Lock is tested first so it wins over a coincident timeout.
            if (lock_s) begin
              state_q <= STABLE;
              timer_q <= '0;
            end else if (timer_q == TO_LAST) begin
              state_q   <= PLL_RST;
              timer_q   <= '0;
              pll_rst_q <= 1'b1;
              retry_q   <= sat_inc(retry_q);
            end else begin
              timer_q <= next_t;
            end
          end
          STABLE: begin
            if (!lock_s) begin
              state_q <= WAIT_LOCK;
              timer_q <= '0;
            end else if (timer_q == STABLE_LAST) begin
              state_q   <= RELEASE;
              timer_q   <= '0;
              dom_rst_q <= ENTRY_MASK;
            end else begin
              timer_q <= next_t;
            end
          end
          RELEASE: begin
            if (next_t == REL_END) begin
              state_q   <= RUN;
              timer_q   <= '0;
              dom_rst_q <= '0;
              ready_q   <= 1'b1;
            end else begin
              timer_q   <= next_t;
              dom_rst_q <= rel_mask;
            end
          end
          RUN: begin
            ready_q <= 1'b1;
          end
          default: begin
            state_q   <= PLL_RST;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            dom_rst_q <= '1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dom_rst   = dom_rst_q;
  assign bus.ready     = ready_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters and
// 2-bit status counters so saturation is reachable.
module tb_pll_reset_sequencer;

  localparam int N_DOM = 3;
  localparam int CNT_W = 2;

  logic refclk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n;

  logic [2:0] exp_dom [0:4] = '{3'd6, 3'd4, 3'd4, 3'd0, 3'd0};

  pll_reset_sequencer_if #(.N_DOM(N_DOM), .CNT_W(CNT_W)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .N_DOM        (N_DOM),
    .STAGGER      (2),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
    cycles = 0;
    while (bus.state !== s && cycles < budget) begin
      tick();
      cycles++;
    end
    if (bus.state !== s) check("wait_state_bound", bus.state, s);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, bus.state, 0);
    check({tag, "_pll_rst"}, bus.pll_rst, 1);
    check({tag, "_dom"}, bus.dom_rst, 3'b111);
    check({tag, "_ready"}, bus.ready, 0);
    check({tag, "_retry"}, bus.retry_cnt, 0);
    check({tag, "_loss"}, bus.loss_cnt, 0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Nominal bring-up
    wait_state(3'd1, 50, n);
    check("pll_rst_len", n, 4);
    check("pll_rst_low", bus.pll_rst, 0);
    repeat (10) tick();
    bus.pll_locked = 1'b1;
    wait_state(3'd2, 10, n);
    check("lock_to_stable", n, 3);
    wait_state(3'd3, 20, n);
    check("stable_len", n, 8);
    check("rel_first_dom", bus.dom_rst, 3'b110);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rel_dom_%0d", i), bus.dom_rst, exp_dom[i]);
      check($sformatf("rel_ready_%0d", i), bus.ready, 0);
    end
    tick();
    check("run_state", bus.state, 4);
    check("run_ready", bus.ready, 1);
    check("run_retry", bus.retry_cnt, 0);

    // Lock loss in RUN: 2 sync cycles plus one decision edge
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    check("loss_lat_state", bus.state, 4);
    check("loss_lat_ready", bus.ready, 1);
    tick();
    check("loss_state", bus.state, 0);
    check("loss_dom", bus.dom_rst, 3'b111);
    check("loss_ready", bus.ready, 0);
    check("loss_pll_rst", bus.pll_rst, 1);
    check("loss_cnt1", bus.loss_cnt, 1);
    bus.pll_locked = 1'b1;
    wait_state(3'd4, 60, n);
    check("reseq_len", n, 19);

    // restart_req in RUN, then ignored inside PLL_RST
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    check("rs_run_state", bus.state, 0);
    check("rs_run_loss", bus.loss_cnt, 1);
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    wait_state(3'd1, 20, n);
    check("rs_ignored_len", n, 3);

    // restart_req in RELEASE while dom_rst=110
    wait_state(3'd3, 40, n);
    check("rs_rel_dom_pre", bus.dom_rst, 3'b110);
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    check("rs_rel_state", bus.state, 0);
    check("rs_rel_dom", bus.dom_rst, 3'b111);
    check("rs_rel_retry", bus.retry_cnt, 0);
    check("rs_rel_loss", bus.loss_cnt, 1);

    // Unstable lock: one-cycle drop at STABLE count 5
    wait_state(3'd2, 20, n);
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    tick();
    check("unst_still_stable", bus.state, 2);
    tick();
    check("unst_wait", bus.state, 1);
    check("unst_loss", bus.loss_cnt, 1);
    wait_state(3'd3, 40, n);
    check("unst_relock_len", n, 9);
    wait_state(3'd4, 20, n);
    check("unst_rel_len", n, 6);

    // Lock loss coinciding with restart_req in RUN
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    check("both_state", bus.state, 0);
    check("both_loss", bus.loss_cnt, 2);

    // Lock timeouts with saturation of the 2-bit retry counter
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd1, 20, n);
      check($sformatf("to_rst_len_%0d", i), n, 4);
      wait_state(3'd0, 100, n);
      check($sformatf("to_wait_len_%0d", i), n, 32);
      check($sformatf("to_retry_%0d", i), bus.retry_cnt, (i < 3) ? i + 1 : 3);
      check($sformatf("to_dom_%0d", i), bus.dom_rst, 3'b111);
    end
    bus.pll_locked = 1'b1;
    wait_state(3'd4, 60, n);
    check("to_release_len", n, 19);
    check("to_final_retry", bus.retry_cnt, 3);
    check("to_final_loss", bus.loss_cnt, 2);

    // Asynchronous reset mid-RELEASE
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    wait_state(3'd3, 40, n);
    repeat (2) tick();
    check("mid_rel_dom", bus.dom_rst, 3'b100);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the reset of the main clock PLL and supervises its lock.
- Generates staggered per-domain reset requests for the 24/96/48 MHz domains once lock is stable.
- Runs entirely on the 50 MHz reference clock and sits between the top-level reset and the PLL plus domain reset synchronizers.
- On lock loss or a restart request it re-asserts all domain resets and re-runs the PLL reset sequence. Retry and lock-loss events are counted for status.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retrying (≥2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- N_DOM, 3: number of domain reset outputs (≥1).
- STAGGER, 4: cycles between successive domain reset releases (≥1).
- CNT_W, 8: width of the status counters.

Ports:
- refclk, input, 1: reference clock; sole clock of the block.
- rst, input, 1: asynchronous active-high reset.
- pll_locked, input, 1: PLL lock flag, asynchronous to refclk.
- restart_req, input, 1: refclk-synchronous pulse that forces a full re-sequence.
- pll_rst, output, 1: reset to the PLL.
- dom_rst, output, N_DOM: per-domain reset requests, active-high; downstream synchronizers are assumed per domain.
- ready, output, 1: high while all domains are released and lock is held.
- state, output, 3: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN.
- retry_cnt, output, CNT_W: WAIT_LOCK timeouts, saturating.
- loss_cnt, output, CNT_W: lock losses in RELEASE or RUN, saturating.

Behaviour:
- All outputs are registered.
- On rst: state=PLL_RST, pll_rst=1, dom_rst=all ones, ready=0, retry_cnt=0, loss_cnt=0, timer=0, sync flops=0.
- pll_locked passes through a 2-flop synchronizer to give lock_s. This adds 2 cycles of latency, and all decisions use lock_s.
- PLL_RST:
  - pll_rst=1, dom_rst=all ones.
  - After RST_CYCLES cycles in the state, go to WAIT_LOCK with timer=0; pll_rst is 0 from that cycle on.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE with timer=0.
  - Otherwise, when timer reaches LOCK_TIMEOUT-1, go to PLL_RST and increment retry_cnt, saturating at all ones.
  - If lock_s rises in the same cycle as the timeout, lock wins.
- STABLE:
  - If lock_s=0, return to WAIT_LOCK with timer=0 (not counted).
  - After STABLE_CYCLES consecutive lock_s=1 cycles, go to RELEASE.
- RELEASE:
  - dom_rst[0] clears on the first RELEASE cycle.
  - dom_rst[k] clears STAGGER cycles after dom_rst[k-1].
  - STAGGER cycles after dom_rst[N_DOM-1] clears, go to RUN; ready=1 from the first RUN cycle.
- RUN: hold all outputs.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge: state=PLL_RST, pll_rst=1, dom_rst=all ones, ready=0, loss_cnt+1 (saturating).
- restart_req=1:
  - In any state other than PLL_RST, same action as lock loss but no counter change.
  - In PLL_RST it is ignored; the timer is not restarted.
- Simultaneous lock loss and restart_req in RELEASE/RUN: treated as lock loss, so loss_cnt increments once.
- Reset mid-sequence returns immediately (asynchronously) to the reset values, counters included.
- Domain resets always clear in ascending index order and always assert together; no glitch is allowed on any dom_rst bit.
- Timer width is ceil(log2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER·N_DOM))) + 1. No wrap is possible within any state.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGGER=2, N_DOM=3):
- Nominal bring-up: release rst; raise pll_locked 10 cycles after pll_rst falls.
  - pll_rst is high exactly 4 cycles.
  - STABLE is entered 2–3 cycles after lock rises.
  - dom_rst goes 111→110→100→000 at 2-cycle spacing.
  - ready=1 two cycles after the final clear; retry_cnt=0.
- Lock timeout: hold pll_locked=0.
  - WAIT_LOCK lasts 32 cycles, then pll_rst re-pulses 4 cycles; repeat ×3.
  - retry_cnt=3, dom_rst stays 111.
  - Then assert lock: normal release.
- Unstable lock: in STABLE, drop pll_locked for 1 cycle at count 5.
  - Returns to WAIT_LOCK, loss_cnt=0.
  - Release occurs only after 8 fresh consecutive lock cycles.
- Lock loss in RUN: drop pll_locked.
  - 3 cycles later (2 sync + 1): dom_rst=111, ready=0, pll_rst=1, loss_cnt=1.
  - Re-lock leads to full re-sequence.
- restart_req in RELEASE after dom_rst=110, with pll_locked held high: dom_rst=111 and state=PLL_RST next cycle, both counters unchanged. Also pulse restart_req together with lock loss in RUN: loss_cnt increments by exactly 1.
- Saturation/reset: with CNT_W=2, force 5 timeouts: retry_cnt=3. Assert rst mid-RELEASE: all outputs return to reset values immediately, with no clock edge required.
